slice_concat_packer: RTL

- Parameterised, handshaked bit-slice extractor and concatenator, the sequential successor to the team's fixed vector-slicing logic.
- On each accepted input beat, a configurable bit slice is cut from the beat. Successive slices are concatenated into one wider output word.
- The word is presented on a registered valid/ready output port when FIELDS slices have been collected, or earlier on an explicit flush.
- Used in datapaths that assemble control/status fields from narrow sources.

---
 rtl/slice_concat_packer_if.sv | 45 ++++
 rtl/slice_concat_packer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/slice_concat_packer_if.sv
// -----------------------------------------------------------------------------
// slice_concat_packer_if
//
// Purpose:
//   Bundles the two valid/ready channels of slice_concat_packer: the narrow
//   input beat stream and the packed output word stream.
//
// Signals:
//   in_valid   producer -> packer  input beat valid
//   in_ready   packer -> producer  packer can take a beat this cycle
//   in_data    producer -> packer  input word (only the configured slice used)
//   in_last    producer -> packer  close the current word after this beat
//   out_valid  packer -> consumer  out_data/out_count valid
//   out_ready  consumer -> packer  consumer takes the word this cycle
//   out_data   packer -> consumer  packed word
//   out_count  packer -> consumer  number of valid fields in out_data
//
// Modports:
//   master  environment side (drives beats, accepts words)
//   slave   packer side
// -----------------------------------------------------------------------------
interface slice_concat_packer_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8,
    parameter int CNT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/slice_concat_packer.sv
// -----------------------------------------------------------------------------
// slice_concat_packer
//
// Purpose:
//   Cuts a fixed bit slice in_data[SLICE_LSB +: SLICE_W] out of every accepted
//   input beat and concatenates successive slices into an OUT_W-bit word. The
//   word is closed after FIELDS slices, or earlier when a beat carries in_last,
//   and is then presented on a registered valid/ready output.
//
// Parameters:
//   IN_W       input beat width
//   SLICE_LSB  LSB of the slice inside in_data   (SLICE_LSB+SLICE_W <= IN_W)
//   SLICE_W    slice width
//   FIELDS     slices per output word            (>= 2)
//   MSB_FIRST  1: first slice in the top field, 0: first slice in the bottom
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; discards any partial or pending word
//   bus    slice_concat_packer_if.slave (input beats and output words)
//
// Timing:
//   out_valid rises the cycle after the closing beat is accepted. With
//   out_ready held high the block sustains one beat per cycle; a new word may
//   replace a word being delivered on the same edge without a bubble.
// -----------------------------------------------------------------------------
module slice_concat_packer #(
    parameter int IN_W      = 8,
    parameter int SLICE_LSB = 2,
    parameter int SLICE_W   = 2,
    parameter int FIELDS    = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    slice_concat_packer_if.slave bus
);
    localparam int OUT_W = SLICE_W * FIELDS;
    localparam int CNT_W = $clog2(FIELDS + 1);

    // Fill index of the slice that completes a word.
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(FIELDS - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIELDS);

    // FILL: no stalled word. HOLD: a word was pending last cycle and the
    // consumer did not take it, so the output registers must not move.
    typedef enum logic {
        S_FILL,
        S_HOLD
    } state_e;

    state_e           state_q,     state_d;
    logic [OUT_W-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [OUT_W-1:0] out_data_q,  out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_valid_q, out_valid_d;

    logic               in_ready;
    logic               accept;
    logic               deliver;
    logic               close;
    logic [SLICE_W-1:0] slice;
    logic [OUT_W-1:0]   merged;
    logic [CNT_W-1:0]   cnt_inc;

    // Bits of in_data outside the slice are deliberately not consumed; the
    // reduction only keeps lint quiet and feeds nothing.
    logic unused_in_bits;
    assign unused_in_bits = ^bus.in_data;

    // Zero-extends a slice and shifts it into field k of the output word.
    function automatic logic [OUT_W-1:0] place_slice(
        input logic [SLICE_W-1:0] s,
        input logic [CNT_W-1:0]   k
    );
        logic [OUT_W-1:0] ext;
        int               sh;
        ext = OUT_W'(s);
        if (MSB_FIRST) begin
            sh = OUT_W - SLICE_W - int'(k) * SLICE_W;
        end else begin
            sh = int'(k) * SLICE_W;
        end
        return ext << sh;
    endfunction

    // The input side only stalls while a word sits unclaimed; it never looks
    // at in_valid, so there is no combinational loop through the producer.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign deliver  = out_valid_q && bus.out_ready;

    assign slice   = bus.in_data[SLICE_LSB +: SLICE_W];
    assign merged  = acc_q | place_slice(slice, cnt_q);
    assign cnt_inc = cnt_q + CNT_W'(1);

    // in_last on a beat that also fills the word still yields a single close.
    assign close = accept && ((cnt_q == LAST_IDX) || bus.in_last);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;

        if (deliver) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (close) begin
                // Overrides the delivery clear above: a word handed over on
                // this edge is replaced by the new one with no bubble.
                out_data_d  = merged;
                out_count_d = cnt_inc;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d = merged;
                cnt_d = cnt_inc;
            end
        end

        state_d = (out_valid_q && !bus.out_ready) ? S_HOLD : S_FILL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the output word and count are cleared together with the
            // control state, so nothing assembled before reset is ever visible.
            state_q     <= S_FILL;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;

    // Protocol properties; synthesis ignores them.
    a_hold_has_word: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q == S_HOLD) |-> out_valid_q
    );

    a_stall_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (out_valid_q && !bus.out_ready) |=>
            (out_valid_q && $stable(out_data_q) && $stable(out_count_q))
    );

    a_count_range: assert property (
        @(posedge clk) disable iff (!rst_n)
        out_valid_q |-> ((out_count_q != '0) && (out_count_q <= FULL_COUNT))
    );

    a_fill_range: assert property (
        @(posedge clk) disable iff (!rst_n)
        cnt_q <= LAST_IDX
    );
endmodule
